inst_sram_slave: RTL

- Responder (memory side) for the fetch-stage instruction SRAM interface: accepts en/we/addr/wdata requests and returns instruction words.
- Synchronous word-organised RAM with byte-lane writes and an address window check.
- Optional fixed wait states, signalled to the pipeline through a stall request.
- Sits between the IF stage and the instruction memory; it is also the bench memory model for core bring-up.

---
 rtl/inst_sram_slave.sv | 112 +++++++++++
 1 files changed

// File: rtl/inst_sram_slave.sv
// Instruction SRAM responder for the fetch stage.
// Word RAM with byte-lane writes, window check and optional read wait states.
module inst_sram_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_LOG2  = 14,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] RESET_RDATA = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_we,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  output logic        rdata_valid,
  output logic        addr_err,
  output logic        stallreq
);

  localparam int         WORDS   = 1 << DEPTH_LOG2;
  localparam logic [2:0] W3      = WAIT_CYCLES[2:0];
  localparam bit         NO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t                  state;
  logic [2:0]              cnt;
  logic [DEPTH_LOG2-1:0]   lat_idx;
  logic                    lat_ok;
  logic [31:0]             mem [0:WORDS-1];

  logic [31:0]             req_off;
  logic [DEPTH_LOG2-1:0]   req_idx;
  logic                    req_ok;
  logic                    is_rd;
  logic                    is_wr;

  // Window check: addresses below the base wrap to a huge offset.
  assign req_off = inst_sram_addr - ADDR_BASE;
  assign req_idx = req_off[DEPTH_LOG2+1:2];
  assign req_ok  = ((req_off >> (DEPTH_LOG2 + 2)) == 32'd0) &&
                   (inst_sram_addr[1:0] == 2'b00);

  assign is_rd = inst_sram_en && (inst_sram_we == 4'b0000) &&
                 (state == IDLE);
  assign is_wr = inst_sram_en && (inst_sram_we != 4'b0000) &&
                 (state == IDLE);

  // Stall for exactly WAIT_CYCLES cycles starting in the request cycle.
  assign stallreq = !NO_WAIT &&
                    ((is_rd) || (state == WAIT && cnt > 3'd1));

  // Byte-lane RAM writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (rst_n && is_wr && req_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (inst_sram_we[i]) begin
          mem[req_idx][8*i +: 8] <= inst_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Request FSM with registered read data and status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= 3'd0;
      lat_idx         <= '0;
      lat_ok          <= 1'b0;
      inst_sram_rdata <= RESET_RDATA;
      rdata_valid     <= 1'b0;
      addr_err        <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      addr_err    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (is_wr) begin
            addr_err <= !req_ok;
          end else if (is_rd) begin
            if (NO_WAIT) begin
              rdata_valid     <= 1'b1;
              addr_err        <= !req_ok;
              inst_sram_rdata <= req_ok ? mem[req_idx] : RESET_RDATA;
            end else begin
              lat_idx <= req_idx;
              lat_ok  <= req_ok;
              cnt     <= W3;
              state   <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state           <= IDLE;
            rdata_valid     <= 1'b1;
            addr_err        <= !lat_ok;
            inst_sram_rdata <= lat_ok ? mem[lat_idx] : RESET_RDATA;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
